// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - frames captured BRAM samples into a byte stream
//
// Reads captured samples back from the capture BRAM after a capture and
// emits them as one frame: header, 3-byte big-endian sample count,
// data bytes in address order, then the XOR checksum of the data bytes.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   start, abort      single-cycle control pulses (abort wins over start)
//   sample_count      valid bytes in BRAM, latched when start is accepted
//   rd_en, rd_addr    BRAM read port; rd_data returns one cycle after rd_en
//   tx_data/valid/ready  byte stream towards the UART transmitter
//   busy, done        frame in progress / pulse when checksum byte accepted

module capture_readout #(
    parameter int          ADDR_W = 18,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   sample_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CNT2, S_CNT1, S_CNT0,
        S_RD_REQ, S_RD_WAIT, S_DATA, S_CSUM
    } state_t;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   index_q;
    logic [ADDR_W:0]   index_inc;
    logic [7:0]        csum_q;
    logic [7:0]        data_q;
    logic [23:0]       len24;
    logic              fire;
    logic              start_ok;

    assign len24     = 24'(len_q);
    assign index_inc = index_q + 1'b1;
    // tx_valid is a pure function of state, so fire never feeds back into it.
    assign fire      = tx_valid && tx_ready;
    assign start_ok  = (state == S_IDLE) && start && !abort;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start_ok) state_nxt = S_HDR;
                S_HDR:     if (fire) state_nxt = S_CNT2;
                S_CNT2:    if (fire) state_nxt = S_CNT1;
                S_CNT1:    if (fire) state_nxt = S_CNT0;
                S_CNT0:    if (fire) state_nxt = (len_q == '0) ? S_CSUM : S_RD_REQ;
                S_RD_REQ:  state_nxt = S_RD_WAIT;
                S_RD_WAIT: state_nxt = S_DATA;
                S_DATA:    if (fire) state_nxt = (index_inc == len_q) ? S_CSUM : S_RD_REQ;
                S_CSUM:    if (fire) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame datapath: length, read index, checksum, captured byte, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q   <= '0;
            index_q <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                len_q   <= (sample_count > CAPACITY) ? CAPACITY : sample_count;
                index_q <= '0;
                csum_q  <= '0;
            end
            // An abort during RD_WAIT drops the returning BRAM byte.
            if (state == S_RD_WAIT && !abort) begin
                data_q <= rd_data;
                csum_q <= csum_q ^ rd_data;
            end
            if (state == S_DATA && fire && !abort) begin
                index_q <= index_inc;
            end
            if (state == S_CSUM && fire && !abort) begin
                done <= 1'b1;
            end
        end
    end

    // Output decode
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = index_q[ADDR_W-1:0];
        busy     = (state != S_IDLE);
        case (state)
            S_HDR:    begin tx_data = HEADER;       tx_valid = 1'b1; end
            S_CNT2:   begin tx_data = len24[23:16]; tx_valid = 1'b1; end
            S_CNT1:   begin tx_data = len24[15:8];  tx_valid = 1'b1; end
            S_CNT0:   begin tx_data = len24[7:0];   tx_valid = 1'b1; end
            S_RD_REQ: rd_en = 1'b1;
            S_DATA:   begin tx_data = data_q;       tx_valid = 1'b1; end
            S_CSUM:   begin tx_data = csum_q;       tx_valid = 1'b1; end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - scoreboard bench for capture_readout

module tb_capture_readout;

    localparam int AW  = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   sample_count = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    capture_readout #(.ADDR_W(AW), .HEADER(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sample_count(sample_count), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [CAP];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int ready_mode = 1;   // 0: hold low, 1: always ready, 2: random
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      tx_ready = 1'b0;
        else if (ready_mode == 1) tx_ready = 1'b1;
        else                      tx_ready = 1'($urandom_range(0, 1));
    end

    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int popped = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int exp_addr = 0;
    logic [AW-1:0] last_addr = '0;
    logic p_stall = 1'b0;
    logic p_abort = 1'b0;
    logic [7:0] p_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor_step();
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall && !p_abort) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(p_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    check("stream_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                popped++;
            end
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(exp_addr));
                exp_addr++;
                rd_cnt++;
                last_addr = rd_addr;
            end
            if (done) done_cnt++;
            p_stall = tx_valid && !tx_ready;
            p_data  = tx_data;
            p_abort = abort;
        end
    endtask

    // Reference frame: header, 24-bit big-endian clamped count, data, XOR.
    task automatic push_frame(input int sc, output int len);
        logic [7:0] x;
        x = 8'h00;
        len = (sc > CAP) ? CAP : sc;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len >> 16));
        exp_q.push_back(8'(len >> 8));
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem[i]);
            x ^= mem[i];
        end
        exp_q.push_back(x);
    endtask

    task automatic pulse_start(input int sc, input logic ab);
        @(posedge clk); #1;
        start = 1'b1;
        abort = ab;
        sample_count = sc[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_frame(input int sc, input logic extra_start);
        int len;
        int d0;
        int n;
        exp_addr = 0;
        rd_cnt = 0;
        d0 = done_cnt;
        push_frame(sc, len);
        pulse_start(sc, 1'b0);
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk);
            n++;
            if (extra_start && n == 5) begin
                start = 1'b1;
                sample_count = 3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("frame_timeout", 32'(n < 20000), 32'd1);
        repeat (3) @(negedge clk);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("rd_count", 32'(rd_cnt), 32'(len));
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"},  32'(tx_data),  32'd0);
        check({tag, "_rd_en"},    32'(rd_en),    32'd0);
        check({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
    endtask

    initial begin
        int len;
        int d0;
        int n;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal frame
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        run_frame(4, 1'b0);
        check("normal_last_addr", 32'(last_addr), 32'd3);

        // Empty capture
        run_frame(0, 1'b0);

        // Back-pressure on the same data
        ready_mode = 2;
        run_frame(4, 1'b0);

        // Random frames under random back-pressure
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 48; i++) mem[i] = 8'($urandom);
            run_frame(int'($urandom_range(0, 40)), 1'b0);
        end

        // Full buffer and clamp
        ready_mode = 1;
        for (int i = 0; i < CAP; i++) mem[i] = 8'(i);
        run_frame(CAP, 1'b0);
        check("full_last_addr", 32'(last_addr), 32'(CAP - 1));
        run_frame((1 << (AW + 1)) - 1, 1'b0);
        check("clamp_last_addr", 32'(last_addr), 32'(CAP - 1));

        // Abort after two data bytes, then a fresh frame
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        exp_addr = 0;
        d0 = done_cnt;
        popped = 0;
        push_frame(10, len);
        pulse_start(10, 1'b0);
        n = 0;
        while (popped < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_wait", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame(5, 1'b0);

        // Start while busy is ignored
        run_frame(6, 1'b1);

        // Simultaneous start and abort in idle
        pulse_start(4, 1'b1);
        @(negedge clk);
        check("startabort_busy", 32'(busy), 32'd0);
        check("startabort_valid", 32'(tx_valid), 32'd0);

        // Reset mid-frame
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        exp_addr = 0;
        popped = 0;
        push_frame(8, len);
        pulse_start(8, 1'b0);
        n = 0;
        while (popped < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ready_mode = 0;
        while (!(tx_valid && !tx_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reset_wait", 32'(n < 400), 32'd1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        run_frame(8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
